// File: rtl/pe_psum_accumulator_if.sv
// Handshake bundle for the PE partial-sum accumulator: command, term stream and result stream.
// The master side drives commands and terms; the slave side is the accumulator.
interface pe_psum_accumulator_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic                 start;
   logic [CNT_W-1:0]     len;
   logic                 in_valid;
   logic                 in_ready;
   logic [2*WIDTH-1:0]   in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_data;
   logic                 out_ovf;
   logic                 busy;

   modport master (
      output start, len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, busy
   );

   modport slave (
      input  start, len, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf, busy
   );
endinterface

// File: rtl/pe_psum_accumulator.sv
// Accumulates a fixed-length stream of unsigned PE product terms into a 2*WIDTH-bit sum
// with a sticky carry flag, then holds the result until the consumer takes it.
module pe_psum_accumulator #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   pe_psum_accumulator_if.slave     bus
);
   localparam int DW = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [DW-1:0]       acc_reg, acc_next;
   logic                ovf_reg, ovf_next;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic [CNT_W-1:0]    len_reg, len_next;

   logic [DW:0]         sum_ext;
   logic [CNT_W-1:0]    count_inc;

   // One extra bit captures the carry-out of each addition.
   assign sum_ext   = {1'b0, acc_reg} + {1'b0, bus.in_data};
   assign count_inc = count_reg + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         ovf_reg   <= 1'b0;
         count_reg <= '0;
         len_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         ovf_reg   <= ovf_next;
         count_reg <= count_next;
         len_reg   <= len_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      ovf_next   = ovf_reg;
      count_next = count_reg;
      len_next   = len_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               acc_next   = '0;
               ovf_next   = 1'b0;
               count_next = '0;
               len_next   = bus.len;
               state_next = (bus.len == '0) ? DONE : ACC;
            end
         end
         ACC: begin
            if (bus.in_valid) begin
               acc_next   = sum_ext[DW-1:0];
               ovf_next   = ovf_reg | sum_ext[DW];
               count_next = count_inc;
               if (count_inc == len_reg) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Result outputs are gated so they read zero outside DONE, including during reset.
   assign bus.in_ready  = (state_reg == ACC);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.out_data  = (state_reg == DONE) ? acc_reg : '0;
   assign bus.out_ovf   = (state_reg == DONE) ? ovf_reg : 1'b0;
   assign bus.busy      = (state_reg == ACC) || (state_reg == DONE);
endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Self-checking bench for pe_psum_accumulator: directed table, hand-written corner
// sequences and randomized transactions against an arithmetic reference model.
module tb_pe_psum_accumulator;
   localparam int WIDTH = 8;
   localparam int CNT_W = 8;
   localparam int DW    = 2 * WIDTH;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [DW-1:0] cur_terms [8];

   pe_psum_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   pe_psum_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            n;
      int            gap;
      int            hold;
      logic [DW-1:0] t0, t1, t2, t3;
      logic [DW-1:0] exp_d;
      logic          exp_o;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
      chk({tag, "_out_ovf"},   32'(bus.out_ovf),   32'd0);
      chk({tag, "_busy"},      32'(bus.busy),      32'd0);
   endtask

   // Issues start with n terms from cur_terms, optional bubbles between beats and
   // optional DONE backpressure cycles with start/in_valid pulsed, then accepts the result.
   task automatic run_txn(input int n, input int gap, input int hold,
                          input logic [DW-1:0] exp_d, input logic exp_o, input string tag);
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = CNT_W'(n);
      @(negedge clk);
      bus.start = 1'b0;
      bus.len   = 8'hFF;
      for (int i = 0; i < n; i++) begin
         chk("in_ready_acc", 32'(bus.in_ready), 32'd1);
         chk("out_valid_early", 32'(bus.out_valid), 32'd0);
         bus.in_valid = 1'b1;
         bus.in_data  = cur_terms[i];
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_data  = DW'($urandom);
         if (i != n - 1) begin
            for (int g = 0; g < gap; g++) begin
               chk("bubble_busy", 32'(bus.busy), 32'd1);
               @(negedge clk);
            end
         end
      end
      chk("out_valid_done", 32'(bus.out_valid), 32'd1);
      chk("out_data",       32'(bus.out_data),  32'(exp_d));
      chk("out_ovf",        32'(bus.out_ovf),   32'(exp_o));
      chk("busy_done",      32'(bus.busy),      32'd1);
      chk("in_ready_done",  32'(bus.in_ready),  32'd0);
      for (int h = 0; h < hold; h++) begin
         bus.start    = 1'b1;
         bus.len      = 8'd3;
         bus.in_valid = 1'b1;
         bus.in_data  = DW'($urandom);
         @(negedge clk);
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_out_data",  32'(bus.out_data),  32'(exp_d));
         chk("hold_out_ovf",   32'(bus.out_ovf),   32'(exp_o));
         chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
      end
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      all_zero("after_accept");
      $display("txn %s: len=%0d gap=%0d hold=%0d exp_data=0x%04h exp_ovf=%0d got_checks=%0d errors=%0d",
               tag, n, gap, hold, exp_d, exp_o, checks, errors);
   endtask

   // Reference: the true sum of all terms; the result is its low bits, and a carry was
   // seen at some beat exactly when the true sum reaches 2^DW.
   task automatic model(input int n, output logic [DW-1:0] d, output logic o);
      longint total;
      total = 0;
      for (int i = 0; i < n; i++) total += longint'(cur_terms[i]);
      d = DW'(total);
      o = (total >= (longint'(1) << DW));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] md;
      logic          mo;
      int            n;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.len = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;

      vecs[0] = '{n:4, gap:0, hold:0, t0:16'd1,    t1:16'd2,    t2:16'd3,    t3:16'd4, exp_d:16'd10,   exp_o:1'b0};
      vecs[1] = '{n:2, gap:0, hold:0, t0:16'hFFFF, t1:16'h0002, t2:16'h0,    t3:16'h0, exp_d:16'h0001, exp_o:1'b1};
      vecs[2] = '{n:2, gap:0, hold:5, t0:16'h0100, t1:16'h0023, t2:16'h0,    t3:16'h0, exp_d:16'h0123, exp_o:1'b0};
      vecs[3] = '{n:0, gap:0, hold:0, t0:16'h0,    t1:16'h0,    t2:16'h0,    t3:16'h0, exp_d:16'h0000, exp_o:1'b0};
      vecs[4] = '{n:3, gap:2, hold:0, t0:16'd5,    t1:16'd7,    t2:16'd9,    t3:16'h0, exp_d:16'd21,   exp_o:1'b0};
      vecs[5] = '{n:3, gap:1, hold:1, t0:16'h8000, t1:16'h8000, t2:16'h0001, t3:16'h0, exp_d:16'h0001, exp_o:1'b1};
      vecs[6] = '{n:1, gap:0, hold:0, t0:16'h1234, t1:16'h0,    t2:16'h0,    t3:16'h0, exp_d:16'h1234, exp_o:1'b0};

      #12;
      all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         cur_terms[0] = vecs[v].t0;
         cur_terms[1] = vecs[v].t1;
         cur_terms[2] = vecs[v].t2;
         cur_terms[3] = vecs[v].t3;
         run_txn(vecs[v].n, vecs[v].gap, vecs[v].hold, vecs[v].exp_d, vecs[v].exp_o,
                 $sformatf("vec%0d", v));
      end

      // Asynchronous reset in the middle of an accumulation.
      cur_terms[0] = 16'd1;
      cur_terms[1] = 16'd2;
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = 8'd4;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = cur_terms[i];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("pre_reset_in_ready", 32'(bus.in_ready), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      all_zero("async_reset");
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      all_zero("post_release");
      @(negedge clk);
      all_zero("no_stale_result");
      cur_terms[0] = 16'h00AA;
      run_txn(1, 0, 0, 16'h00AA, 1'b0, "after_reset");

      // Reset while holding a result in DONE.
      cur_terms[0] = 16'h0042;
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = 8'd1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = cur_terms[0];
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("done_before_reset", 32'(bus.out_valid), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      all_zero("reset_in_done");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      all_zero("done_discarded");

      for (int t = 0; t < 24; t++) begin
         n = $urandom_range(0, 6);
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) cur_terms[i] = DW'($urandom_range(16'hC000, 16'hFFFF));
            else                           cur_terms[i] = DW'($urandom_range(0, 255));
         end
         model(n, md, mo);
         run_txn(n, $urandom_range(0, 2), $urandom_range(0, 3), md, mo, $sformatf("rnd%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
